// File: rtl/direction_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : direction_input_pkg
//  Description : Shared direction codes, FSM state encodings and helpers for
//                the push-button front end of the game controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package direction_input_pkg;

    // One-hot move codes, matching the controller's case decode
    localparam logic [3:0] c_DIR_NONE  = 4'b0000;
    localparam logic [3:0] c_DIR_LEFT  = 4'b0001;
    localparam logic [3:0] c_DIR_RIGHT = 4'b0010;
    localparam logic [3:0] c_DIR_DOWN  = 4'b0100;
    localparam logic [3:0] c_DIR_UP    = 4'b1000;

    // Direction FSM encodings
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    // True when exactly one of the four keys is pressed
    function automatic logic f_is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/direction_input_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Synchronises one raw active-low button and debounces it into
//                an active-high level that only changes after the input has
//                disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_n,
    output logic level
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_synced;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    // Two-flop synchroniser, then an active-high copy of the synced value
    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_synced <= 1'b0;
        end else begin
            r_meta   <= raw_n;
            r_sync   <= r_meta;
            r_synced <= ~r_sync;
        end
    end

    // Count consecutive disagreement; flip the level once it has persisted
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_synced == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/direction_input.sv
`default_nettype none
// ============================================================================
//  Module      : direction_input
//  Description : Front end for the controller's direction/start inputs.
//                Debounces four direction keys and a start key and emits one
//                single-cycle one-hot direction pulse per press, plus a
//                single-cycle start pulse. Start wins over direction.
//  Revision    : 1.0 - initial release
// ============================================================================
module direction_input
    import direction_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       start_n,
    output logic [3:0] direction,
    output logic       start
);

    // After reset the debounced levels read "released" until the sync chain
    // and debounce window have refilled. Releases seen during that window are
    // not trusted, so a key held across reset cannot look like a new press.
    localparam int c_SETTLE   = DEBOUNCE_CYCLES + 3;
    localparam int c_SETTLE_W = $clog2(c_SETTLE + 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_VAL = c_SETTLE_W'(c_SETTLE);

    logic [3:0]            w_keys;
    logic                  w_start_lvl;
    logic                  w_settled;
    logic                  w_start_fire;
    logic [0:0]            w_state_nxt;
    logic [3:0]            w_dir_nxt;
    logic                  w_armed_nxt;

    logic [0:0]            r_state;
    logic [3:0]            r_direction;
    logic                  r_start;
    logic                  r_start_armed;
    logic [c_SETTLE_W-1:0] r_settle;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_key (
                .clock (clock),
                .reset (reset),
                .raw_n (key_n[gi]),
                .level (w_keys[gi])
            );
        end
    endgenerate

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_start (
        .clock (clock),
        .reset (reset),
        .raw_n (start_n),
        .level (w_start_lvl)
    );

    assign w_settled    = (r_settle == c_SETTLE_VAL);
    assign w_start_fire = w_start_lvl && r_start_armed;

    // Post-reset settle timer, saturating once the input pipeline is full
    always_ff @(posedge clock) begin
        if (reset) begin
            r_settle <= '0;
        end else if (!w_settled) begin
            r_settle <= r_settle + c_SETTLE_W'(1);
        end
    end

    // Next-state, next-output and start arming decisions
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = c_DIR_NONE;
        w_armed_nxt = r_start_armed;

        if (!w_start_lvl) begin
            if (w_settled) begin
                w_armed_nxt = 1'b1;
            end
        end else if (w_start_fire) begin
            w_armed_nxt = 1'b0;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (w_keys != 4'd0) begin
                    // Any press leaves IDLE; only an unambiguous, unpreempted
                    // single key produces a move.
                    w_state_nxt = c_ST_HOLD;
                    if (f_is_onehot(w_keys) && !w_start_fire) begin
                        w_dir_nxt = w_keys;
                    end
                end
            end
            c_ST_HOLD: begin
                if ((w_keys == 4'd0) && w_settled) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_HOLD;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_ST_HOLD;
            r_direction   <= c_DIR_NONE;
            r_start       <= 1'b0;
            r_start_armed <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_direction   <= w_dir_nxt;
            r_start       <= w_start_fire;
            r_start_armed <= w_armed_nxt;
        end
    end

    assign direction = r_direction;
    assign start     = r_start;

    // Direction is idle or names exactly one key
    assert property (@(posedge clock) $onehot0(r_direction));

endmodule
`default_nettype wire

// File: tb/tb_direction_input.sv
`default_nettype none
// ============================================================================
//  Module      : tb_direction_input
//  Description : Self-checking bench for direction_input with a behavioural
//                model of the button front end and randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_direction_input;

    localparam int N      = 4;
    localparam int HN     = N + 3;   // raw samples remembered per input
    localparam int SETTLE = N + 3;   // cycles after reset before releases count

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] key_n   = 4'hF;
    logic       start_n = 1'b1;
    logic [3:0] direction;
    logic       start;

    int checks = 0;
    int errors = 0;

    direction_input #(
        .DEBOUNCE_CYCLES (N),
        .CNT_W           (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_n     (key_n),
        .start_n   (start_n),
        .direction (direction),
        .start     (start)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: an input's level changes once the last N synced
    // samples (raw delayed by 3 cycles) all disagree with it. A press is
    // honoured when all keys had been released; start fires once per press.
    // ------------------------------------------------------------------
    logic [4:0] hist [HN];
    logic [4:0] m_lvl;
    bit         m_need_release;
    bit         m_armed;
    int         m_since_reset;
    logic [3:0] exp_dir;
    logic       exp_start;
    bit         m_live = 1'b0;

    int         cyc = 0;
    int         dir_cnt = 0;
    int         st_cnt = 0;
    int         dir_cyc = -1;
    logic [3:0] dir_last = 4'd0;

    always @(posedge clock) begin
        logic [4:0] raw;
        logic [3:0] keys;
        logic       fire;
        bit         all_diff;
        cyc++;
        raw = ~{start_n, key_n};
        if (reset) begin
            for (int i = 0; i < HN; i++) hist[i] = '0;
            m_lvl          = '0;
            m_need_release = 1'b1;
            m_armed        = 1'b0;
            m_since_reset  = 0;
            exp_dir        = 4'd0;
            exp_start      = 1'b0;
            m_live         = 1'b1;
        end else begin
            keys      = m_lvl[3:0];
            fire      = m_lvl[4] && m_armed;
            exp_start = fire;
            exp_dir   = 4'd0;
            if (!m_need_release) begin
                if (keys != 4'd0) begin
                    if ($countones(keys) == 1 && !fire) exp_dir = keys;
                    m_need_release = 1'b1;
                end
            end else if (keys == 4'd0 && m_since_reset >= SETTLE) begin
                m_need_release = 1'b0;
            end
            if (!m_lvl[4]) begin
                if (m_since_reset >= SETTLE) m_armed = 1'b1;
            end else if (fire) begin
                m_armed = 1'b0;
            end
            for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = raw;
            for (int b = 0; b < 5; b++) begin
                all_diff = 1'b1;
                for (int j = 3; j < HN; j++) if (hist[j][b] == m_lvl[b]) all_diff = 1'b0;
                if (all_diff) m_lvl[b] = ~m_lvl[b];
            end
            m_since_reset++;
        end
        #1;
        if (m_live) begin
            check("direction", {28'd0, direction}, {28'd0, exp_dir});
            check("start", {31'd0, start}, {31'd0, exp_start});
            check("dir_onehot0", {31'd0, $onehot0(direction)}, 32'd1);
            if (direction != 4'd0) begin
                dir_cnt++;
                dir_last = direction;
                dir_cyc  = cyc;
            end
            if (start) st_cnt++;
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(input logic [3:0] k, input logic s);
        @(negedge clock);
        key_n   = k;
        start_n = s;
    endtask

    task automatic clear_log();
        dir_cnt  = 0;
        st_cnt   = 0;
        dir_cyc  = -1;
        dir_last = 4'd0;
    endtask

    initial begin
        int         press_edge;
        logic [3:0] kk;
        logic       ss;

        // Reset state
        ticks(2);
        check("reset_direction", {28'd0, direction}, 32'd0);
        check("reset_start", {31'd0, start}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ticks(12);

        // Single left press: one pulse, 7 cycles after the sampling edge
        clear_log();
        drive(4'b1110, 1'b1);
        press_edge = cyc + 1;
        ticks(20);
        check("left_count", dir_cnt, 1);
        check("left_code", {28'd0, dir_last}, 32'h1);
        check("left_latency", dir_cyc, press_edge + 7);

        // Up held long: still one pulse
        drive(4'b1111, 1'b1);
        ticks(10);
        clear_log();
        drive(4'b0111, 1'b1);
        ticks(100);
        check("up_count", dir_cnt, 1);
        check("up_code", {28'd0, dir_last}, 32'h8);

        // Bouncing key never settles
        drive(4'b1111, 1'b1);
        ticks(10);
        clear_log();
        for (int r = 0; r < 3; r++) begin
            drive(4'b1110, 1'b1);
            ticks(1);
            drive(4'b1111, 1'b1);
            ticks(1);
        end
        ticks(20);
        check("bounce_count", dir_cnt, 0);

        // Two keys together are rejected; a later single key works
        clear_log();
        drive(4'b1100, 1'b1);
        ticks(20);
        check("dual_count", dir_cnt, 0);
        drive(4'b1111, 1'b1);
        ticks(10);
        drive(4'b1101, 1'b1);
        ticks(20);
        check("right_count", dir_cnt, 1);
        check("right_code", {28'd0, dir_last}, 32'h2);

        // Key held across reset gives nothing until pressed again
        drive(4'b1111, 1'b1);
        ticks(10);
        drive(4'b1011, 1'b1);
        ticks(20);
        clear_log();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        ticks(30);
        check("held_reset_count", dir_cnt, 0);
        drive(4'b1111, 1'b1);
        ticks(12);
        drive(4'b1011, 1'b1);
        ticks(20);
        check("down_count", dir_cnt, 1);
        check("down_code", {28'd0, dir_last}, 32'h4);

        // Start together with a key: start only, once
        drive(4'b1111, 1'b1);
        ticks(12);
        clear_log();
        drive(4'b1110, 1'b0);
        ticks(20);
        check("start_count", st_cnt, 1);
        check("start_dir_suppressed", dir_cnt, 0);
        ticks(50);
        check("start_held_count", st_cnt, 1);
        check("start_held_dir", dir_cnt, 0);

        // Randomized activity, checked every cycle against the model
        drive(4'b1111, 1'b1);
        ticks(12);
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 49) == 0) begin
                @(negedge clock);
                reset = 1'b1;
                ticks($urandom_range(1, 2));
                reset = 1'b0;
            end
            kk = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            ss = ($urandom_range(0, 3) != 0);
            drive(kk, ss);
            if ($urandom_range(0, 3) == 0) ticks($urandom_range(8, 20));
            else ticks($urandom_range(0, 5));
        end
        drive(4'b1111, 1'b1);
        ticks(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
